// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the LEGv8 exception controller.
// Holds the controller state encoding, the exception syndrome codes and the
// default exception vector address.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_ENTER,
    ST_HANDLER,
    ST_LEAVE,
    ST_HALT
  } exc_state_t;

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_INVOP  = 4'b0001;
  localparam logic [3:0] ESR_IRQ    = 4'b0010;
  localparam logic [3:0] ESR_DFAULT = 4'b1111;

  localparam logic [63:0] DEFAULT_VECTOR_ADDR = 64'hD8;

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder/interrupt/fetch-redirect bundle of the exception controller.
//   master : decoder + interrupt source + fetch side (drives the requests)
//   slave  : exception_ctrl (drives redirect, acknowledge and status)
// Requests : InstrValid, NotAnInstr, ERet, ExtIRQ, PC_ID, PC_next
// Responses: ExtIAck, ExcTaken, RetTaken, PCRedirect, ELR, ESR,
//            InHandler, DoubleFault
interface exception_ctrl_if #(
  parameter int AW = 64
);

  logic          InstrValid;
  logic          NotAnInstr;
  logic          ERet;
  logic          ExtIRQ;
  logic [AW-1:0] PC_ID;
  logic [AW-1:0] PC_next;

  logic          ExtIAck;
  logic          ExcTaken;
  logic          RetTaken;
  logic [AW-1:0] PCRedirect;
  logic [AW-1:0] ELR;
  logic [3:0]    ESR;
  logic          InHandler;
  logic          DoubleFault;

  modport master (
    output InstrValid, NotAnInstr, ERet, ExtIRQ, PC_ID, PC_next,
    input  ExtIAck, ExcTaken, RetTaken, PCRedirect, ELR, ESR,
           InHandler, DoubleFault
  );

  modport slave (
    input  InstrValid, NotAnInstr, ERet, ExtIRQ, PC_ID, PC_next,
    output ExtIAck, ExcTaken, RetTaken, PCRedirect, ELR, ESR,
           InHandler, DoubleFault
  );

endinterface

// File: rtl/exception_ctrl_sysregs.sv
// ELR/ESR system registers of the exception controller.
// Ports:
//   clk, reset     : clock, asynchronous active-low clear
//   elr_we, elr_d  : ELR write enable / data
//   esr_we, esr_d  : ESR write enable / data
//   elr, esr       : register contents (MRS read path and return address)
module exc_sysregs #(
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          elr_we,
  input  logic [AW-1:0] elr_d,
  input  logic          esr_we,
  input  logic [3:0]    esr_d,
  output logic [AW-1:0] elr,
  output logic [3:0]    esr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elr <= '0;
      esr <= '0;
    end else begin
      if (elr_we) elr <= elr_d;
      if (esr_we) esr <= esr_d;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer for the LEGv8 core.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : exception_ctrl_if.slave (decoder flags, IRQ, PCs in;
//           redirect, acknowledge, ELR/ESR and status out)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal execution, watching for invalid opcode / IRQ
// ST_ENTER   | ExcTaken pulse, fetch redirected to the vector (IRQ acked)
// ST_HANDLER | running the handler, IRQ masked
// ST_LEAVE   | RetTaken pulse, fetch redirected to ELR
// ST_HALT    | double fault, core halted until reset
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          AW          = 64,
  parameter logic [AW-1:0] VECTOR_ADDR = AW'(DEFAULT_VECTOR_ADDR)
) (
  input logic              clk,
  input logic              reset,
  exception_ctrl_if.slave  bus
);

  exc_state_t    state;
  logic          exc_taken, ret_taken, ext_iack, in_handler, double_fault;
  logic [AW-1:0] pc_redirect;

  logic          elr_we, esr_we;
  logic [AW-1:0] elr_d, elr;
  logic [3:0]    esr_d, esr;

  // ERET outside a handler is treated as an invalid instruction.
  logic run_invop, run_irq, hnd_dfault, hnd_eret;
  assign run_invop  = bus.InstrValid && (bus.NotAnInstr || bus.ERet);
  assign run_irq    = bus.ExtIRQ;
  assign hnd_dfault = bus.InstrValid && bus.NotAnInstr;
  assign hnd_eret   = bus.InstrValid && bus.ERet;

  always_comb begin
    elr_we = 1'b0;
    esr_we = 1'b0;
    elr_d  = bus.PC_ID;
    esr_d  = ESR_NONE;
    case (state)
      ST_RUN: begin
        if (run_invop) begin
          elr_we = 1'b1;
          esr_we = 1'b1;
          esr_d  = ESR_INVOP;
        end else if (run_irq) begin
          elr_we = 1'b1;
          esr_we = 1'b1;
          elr_d  = bus.PC_next;
          esr_d  = ESR_IRQ;
        end
      end
      ST_HANDLER: begin
        if (hnd_dfault) begin
          esr_we = 1'b1;
          esr_d  = ESR_DFAULT;
        end
      end
      default: ;
    endcase
  end

  exc_sysregs #(.AW(AW)) u_sysregs (
    .clk    (clk),
    .reset  (reset),
    .elr_we (elr_we),
    .elr_d  (elr_d),
    .esr_we (esr_we),
    .esr_d  (esr_d),
    .elr    (elr),
    .esr    (esr)
  );

  // Outputs are registered alongside the state so they never depend
  // combinationally on the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      exc_taken    <= 1'b0;
      ret_taken    <= 1'b0;
      ext_iack     <= 1'b0;
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
      pc_redirect  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (run_invop || run_irq) begin
            state       <= ST_ENTER;
            exc_taken   <= 1'b1;
            ext_iack    <= !run_invop;
            pc_redirect <= VECTOR_ADDR;
          end
        end
        ST_ENTER: begin
          state       <= ST_HANDLER;
          exc_taken   <= 1'b0;
          ext_iack    <= 1'b0;
          pc_redirect <= '0;
          in_handler  <= 1'b1;
        end
        ST_HANDLER: begin
          if (hnd_dfault) begin
            state        <= ST_HALT;
            double_fault <= 1'b1;
          end else if (hnd_eret) begin
            state       <= ST_LEAVE;
            ret_taken   <= 1'b1;
            pc_redirect <= elr;
            in_handler  <= 1'b0;
          end
        end
        ST_LEAVE: begin
          state       <= ST_RUN;
          ret_taken   <= 1'b0;
          pc_redirect <= '0;
        end
        ST_HALT: state <= ST_HALT;
        default: begin
          state       <= ST_RUN;
          exc_taken   <= 1'b0;
          ret_taken   <= 1'b0;
          ext_iack    <= 1'b0;
          in_handler  <= 1'b0;
          pc_redirect <= '0;
        end
      endcase
    end
  end

  assign bus.ExcTaken    = exc_taken;
  assign bus.RetTaken    = ret_taken;
  assign bus.ExtIAck     = ext_iack;
  assign bus.InHandler   = in_handler;
  assign bus.DoubleFault = double_fault;
  assign bus.PCRedirect  = pc_redirect;
  assign bus.ELR         = elr;
  assign bus.ESR         = esr;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus a
// randomized run compared against a flag-based behavioural model.
module tb_exception_ctrl;

  localparam int          AW  = 64;
  localparam logic [63:0] VEC = 64'hD8;

  logic clk = 1'b0;
  logic reset;

  exception_ctrl_if #(.AW(AW)) bus ();

  exception_ctrl #(.AW(AW), .VECTOR_ADDR(VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model: one flag per architectural condition.
  bit          m_exc, m_ret, m_ack, m_inh, m_df;
  logic [63:0] m_redir, m_elr;
  logic [3:0]  m_esr;

  function automatic logic [136:0] obs();
    return {bus.ExcTaken, bus.RetTaken, bus.ExtIAck, bus.InHandler, bus.DoubleFault,
            bus.PCRedirect, bus.ELR, bus.ESR};
  endfunction

  function automatic logic [136:0] expv();
    return {m_exc, m_ret, m_ack, m_inh, m_df, m_redir, m_elr, m_esr};
  endfunction

  task automatic mdl_reset();
    m_exc = 0; m_ret = 0; m_ack = 0; m_inh = 0; m_df = 0;
    m_redir = '0; m_elr = '0; m_esr = '0;
  endtask

  task automatic mdl_step();
    if (m_df) begin
      // halted: nothing changes
    end else if (m_exc) begin
      m_exc = 0; m_ack = 0; m_redir = '0; m_inh = 1;
    end else if (m_ret) begin
      m_ret = 0; m_redir = '0;
    end else if (m_inh) begin
      if (bus.InstrValid && bus.NotAnInstr) begin
        m_df = 1; m_esr = 4'hF;
      end else if (bus.InstrValid && bus.ERet) begin
        m_ret = 1; m_redir = m_elr; m_inh = 0;
      end
    end else begin
      if (bus.InstrValid && (bus.NotAnInstr || bus.ERet)) begin
        m_elr = bus.PC_ID; m_esr = 4'h1; m_exc = 1; m_ack = 0; m_redir = VEC;
      end else if (bus.ExtIRQ) begin
        m_elr = bus.PC_next; m_esr = 4'h2; m_exc = 1; m_ack = 1; m_redir = VEC;
      end
    end
  endtask

  task automatic idle();
    bus.InstrValid = 0; bus.NotAnInstr = 0; bus.ERet = 0; bus.ExtIRQ = 0;
    bus.PC_ID = '0; bus.PC_next = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  task automatic exit_handler();
    idle(); bus.InstrValid = 1; bus.ERet = 1;
    cycle();
    idle();
    cycle();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (obs() !== '0) $display("FAIL reset_initial got %h exp 0", obs()); else passed++;
    @(posedge clk); #1;
    reset = 1;
    bus.InstrValid = 1; bus.NotAnInstr = 1; bus.PC_ID = 64'h40;
    cycle();
    checks++; if (bus.ExcTaken !== 1'b1) $display("FAIL reset_pre_enter got %b exp 1", bus.ExcTaken); else passed++;
    idle();
    #2 reset = 0;
    #1 mdl_reset();
    checks++; if (obs() !== '0) $display("FAIL reset_mid_enter got %h exp 0", obs()); else passed++;
    #1 reset = 1;
    cycle();
    checks++; if (obs() !== '0) $display("FAIL reset_run_after got %h exp 0", obs()); else passed++;
    checks++; if (bus.ELR !== 64'h0) $display("FAIL reset_elr got %h exp 0", bus.ELR); else passed++;
  endtask

  task automatic test_invop();
    idle(); bus.InstrValid = 1; bus.NotAnInstr = 1; bus.PC_ID = 64'h40;
    cycle();
    checks++; if (bus.ExcTaken !== 1'b1) $display("FAIL invop_exc got %b exp 1", bus.ExcTaken); else passed++;
    checks++; if (bus.PCRedirect !== VEC) $display("FAIL invop_redir got %h exp %h", bus.PCRedirect, VEC); else passed++;
    checks++; if (bus.ELR !== 64'h40) $display("FAIL invop_elr got %h exp 40", bus.ELR); else passed++;
    checks++; if (bus.ESR !== 4'b0001) $display("FAIL invop_esr got %b exp 0001", bus.ESR); else passed++;
    checks++; if (bus.ExtIAck !== 1'b0) $display("FAIL invop_ack got %b exp 0", bus.ExtIAck); else passed++;
    idle();
    cycle();
    checks++; if (bus.ExcTaken !== 1'b0) $display("FAIL invop_pulse_len got %b exp 0", bus.ExcTaken); else passed++;
    checks++; if (bus.InHandler !== 1'b1) $display("FAIL invop_inhandler got %b exp 1", bus.InHandler); else passed++;
    checks++; if (obs() !== expv()) $display("FAIL invop_model got %h exp %h", obs(), expv()); else passed++;
    exit_handler();
  endtask

  task automatic test_irq();
    idle(); bus.ExtIRQ = 1; bus.PC_next = 64'h104;
    cycle();
    checks++; if ({bus.ExtIAck, bus.ExcTaken} !== 2'b11) $display("FAIL irq_ack_exc got %b exp 11", {bus.ExtIAck, bus.ExcTaken}); else passed++;
    checks++; if (bus.ELR !== 64'h104) $display("FAIL irq_elr got %h exp 104", bus.ELR); else passed++;
    checks++; if (bus.ESR !== 4'b0010) $display("FAIL irq_esr got %b exp 0010", bus.ESR); else passed++;
    idle();
    cycle();
    checks++; if ({bus.ExtIAck, bus.ExcTaken} !== 2'b00) $display("FAIL irq_pulse_len got %b exp 00", {bus.ExtIAck, bus.ExcTaken}); else passed++;
    exit_handler();
    idle(); bus.ExtIRQ = 1; bus.PC_next = 64'h108;
    bus.InstrValid = 1; bus.NotAnInstr = 1; bus.PC_ID = 64'h200;
    cycle();
    checks++; if (bus.ESR !== 4'b0001) $display("FAIL irq_vs_invop_esr got %b exp 0001", bus.ESR); else passed++;
    checks++; if (bus.ELR !== 64'h200) $display("FAIL irq_vs_invop_elr got %h exp 200", bus.ELR); else passed++;
    checks++; if ({bus.ExtIAck, bus.ExcTaken} !== 2'b01) $display("FAIL irq_vs_invop_ack got %b exp 01", {bus.ExtIAck, bus.ExcTaken}); else passed++;
    idle();
    cycle();
    exit_handler();
  endtask

  task automatic test_masking();
    idle(); bus.ExtIRQ = 1; bus.PC_next = 64'h300;
    cycle();
    checks++; if (bus.ExtIAck !== 1'b1) $display("FAIL mask_entry_ack got %b exp 1", bus.ExtIAck); else passed++;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++; if (bus.ExtIAck !== 1'b0 || bus.ExcTaken !== 1'b0) $display("FAIL mask_hold_%0d got ack=%b exc=%b exp 0 0", i, bus.ExtIAck, bus.ExcTaken); else passed++;
    end
    bus.InstrValid = 1; bus.ERet = 1;
    cycle();
    checks++; if (bus.RetTaken !== 1'b1) $display("FAIL mask_ret got %b exp 1", bus.RetTaken); else passed++;
    checks++; if (bus.PCRedirect !== 64'h300) $display("FAIL mask_ret_redir got %h exp 300", bus.PCRedirect); else passed++;
    bus.InstrValid = 0; bus.ERet = 0; bus.PC_next = 64'h444;
    cycle();
    checks++; if ({bus.RetTaken, bus.ExcTaken, bus.InHandler} !== 3'b000) $display("FAIL mask_run_gap got %b exp 000", {bus.RetTaken, bus.ExcTaken, bus.InHandler}); else passed++;
    cycle();
    checks++; if ({bus.ExcTaken, bus.ExtIAck} !== 2'b11) $display("FAIL mask_retake got %b exp 11", {bus.ExcTaken, bus.ExtIAck}); else passed++;
    checks++; if (bus.ELR !== 64'h444) $display("FAIL mask_retake_elr got %h exp 444", bus.ELR); else passed++;
    idle();
    cycle();
    exit_handler();
  endtask

  task automatic test_double_fault();
    idle(); bus.InstrValid = 1; bus.NotAnInstr = 1; bus.PC_ID = 64'h500;
    cycle();
    idle();
    cycle();
    bus.InstrValid = 1; bus.NotAnInstr = 1; bus.ERet = 1; bus.PC_ID = 64'h5A0;
    cycle();
    checks++; if (bus.DoubleFault !== 1'b1) $display("FAIL df_flag got %b exp 1", bus.DoubleFault); else passed++;
    checks++; if (bus.ESR !== 4'hF) $display("FAIL df_esr got %b exp 1111", bus.ESR); else passed++;
    checks++; if (bus.ELR !== 64'h500) $display("FAIL df_elr got %h exp 500", bus.ELR); else passed++;
    checks++; if (bus.InHandler !== 1'b1) $display("FAIL df_inhandler got %b exp 1", bus.InHandler); else passed++;
    for (int i = 0; i < 20; i++) begin
      bus.InstrValid = 1'($urandom); bus.NotAnInstr = 1'($urandom);
      bus.ERet = 1'($urandom); bus.ExtIRQ = 1'($urandom);
      cycle();
      checks++; if ({bus.ExcTaken, bus.RetTaken, bus.ExtIAck, bus.DoubleFault} !== 4'b0001) $display("FAIL df_hold_%0d got %b exp 0001", i, {bus.ExcTaken, bus.RetTaken, bus.ExtIAck, bus.DoubleFault}); else passed++;
    end
    idle();
    #2 reset = 0;
    #1 mdl_reset();
    checks++; if (obs() !== '0) $display("FAIL df_reset got %h exp 0", obs()); else passed++;
    #1 reset = 1;
    cycle();
  endtask

  task automatic test_eret_outside();
    idle(); bus.InstrValid = 1; bus.ERet = 1; bus.PC_ID = 64'h80;
    cycle();
    checks++; if (bus.ESR !== 4'b0001) $display("FAIL eret_out_esr got %b exp 0001", bus.ESR); else passed++;
    checks++; if (bus.ELR !== 64'h80) $display("FAIL eret_out_elr got %h exp 80", bus.ELR); else passed++;
    checks++; if (bus.ExcTaken !== 1'b1) $display("FAIL eret_out_exc got %b exp 1", bus.ExcTaken); else passed++;
    idle();
    cycle();
    exit_handler();
    bus.InstrValid = 0; bus.ERet = 1; bus.NotAnInstr = 1; bus.PC_ID = 64'h90;
    cycle();
    checks++; if ({bus.ExcTaken, bus.InHandler} !== 2'b00) $display("FAIL eret_bubble got %b exp 00", {bus.ExcTaken, bus.InHandler}); else passed++;
    checks++; if (bus.ELR !== 64'h80) $display("FAIL eret_bubble_elr got %h exp 80", bus.ELR); else passed++;
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.InstrValid = ($urandom_range(0, 3) != 0);
      bus.NotAnInstr = ($urandom_range(0, 9) == 0);
      bus.ERet       = ($urandom_range(0, 4) == 0);
      bus.ExtIRQ     = ($urandom_range(0, 5) == 0);
      bus.PC_ID      = {32'($urandom), 32'($urandom)};
      bus.PC_next    = {32'($urandom), 32'($urandom)};
      cycle();
      checks++; if (obs() !== expv()) $display("FAIL rand_%0d got %h exp %h", i, obs(), expv()); else passed++;
      if ($urandom_range(0, 39) == 0) begin
        reset = 0;
        #1 mdl_reset();
        checks++; if (obs() !== '0) $display("FAIL rand_reset_%0d got %h exp 0", i, obs()); else passed++;
        #1 reset = 1;
      end
    end
    idle();
  endtask

  initial begin
    reset = 0;
    idle();
    mdl_reset();
    test_reset();
    test_invop();
    test_irq();
    test_masking();
    test_double_fault();
    test_eret_outside();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
